// File: rtl/mem_arbiter_pkg.sv
// Shared types and limits for the unified-memory arbiter between the IF and MEM stages.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    BUSY_I = 2'd1,
    BUSY_D = 2'd2
  } arb_state_t;

  localparam int unsigned MEM_LAT_MIN = 1;
  localparam int unsigned MEM_LAT_MAX = 15;

  // Bits needed to hold MEM_LAT-1 (never narrower than one bit).
  function automatic int unsigned cnt_width(input int unsigned lat);
    return (lat <= 2) ? 1 : $clog2(lat);
  endfunction

endpackage

// File: rtl/arb_wait_cnt.sv
// Loadable latency down-counter: expire marks the last wait cycle, done pulses the cycle after.
module arb_wait_cnt #(
  parameter int unsigned W = 1
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] load_val,
  output logic         expire,
  output logic         done
);

  logic [W-1:0] cnt;
  logic         active;

  assign expire = active & (cnt == '0);

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt    <= '0;
      active <= 1'b0;
      done   <= 1'b0;
    end else begin
      done <= expire;
      if (load) begin
        cnt    <= load_val;
        active <= 1'b1;
      end else if (expire) begin
        active <= 1'b0;
      end else if (active) begin
        cnt <= cnt - 1'b1;
      end
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// Single-ported memory arbiter for IF/MEM stages with pipeline stall generation.
// Optional fetch anti-starvation is enabled by defining MEM_ARBITER_FAIRNESS_EN.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int unsigned ADDR_W     = 32,
  parameter int unsigned DATA_W     = 32,
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic [DATA_W-1:0] if_rdata,
  output logic              if_ack,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic [DATA_W-1:0] d_rdata,
  output logic              d_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall_fetch,
  output logic              stall_pipe
);

  localparam int unsigned CNT_W = cnt_width(MEM_LAT);

  if (MEM_LAT < MEM_LAT_MIN || MEM_LAT > MEM_LAT_MAX) begin : g_bad_lat
    $error("mem_arbiter: MEM_LAT outside 1..15");
  end
  if (STARVE_MAX < 1) begin : g_bad_starve
    $error("mem_arbiter: STARVE_MAX must be at least 1");
  end

  arb_state_t        state, state_nxt;
  logic              grant_i, grant_d;
  logic              expire, done;
  logic              gnt_d, gnt_we;
  logic [DATA_W-1:0] if_hold, d_hold;
  logic              force_fetch;

`ifdef MEM_ARBITER_FAIRNESS_EN
  localparam int unsigned SW = $clog2(STARVE_MAX + 1);
  logic [SW-1:0] starve;

  assign force_fetch = (starve == SW'(STARVE_MAX));

  always_ff @(posedge clock) begin
    if (reset) begin
      starve <= '0;
    end else if (grant_i) begin
      starve <= '0;
    end else if (grant_d && if_req && !force_fetch) begin
      starve <= starve + 1'b1;
    end
  end
`else
  assign force_fetch = 1'b0;
`endif

  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // The ack cycle is spent in IDLE, so arbitration for the next access overlaps it.
  always_comb begin
    state_nxt = state;
    grant_i   = 1'b0;
    grant_d   = 1'b0;
    unique case (state)
      IDLE: begin
        if (if_req && force_fetch) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end else if (d_req) begin
          grant_d   = 1'b1;
          state_nxt = BUSY_D;
        end else if (if_req) begin
          grant_i   = 1'b1;
          state_nxt = BUSY_I;
        end
      end
      BUSY_I, BUSY_D: begin
        if (expire) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  arb_wait_cnt #(
    .W(CNT_W)
  ) u_wait_cnt (
    .clock   (clock),
    .reset   (reset),
    .load    (grant_i | grant_d),
    .load_val(CNT_W'(MEM_LAT - 1)),
    .expire  (expire),
    .done    (done)
  );

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_en    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      gnt_d     <= 1'b0;
      gnt_we    <= 1'b0;
      if_hold   <= '0;
      d_hold    <= '0;
    end else begin
      mem_en <= grant_i | grant_d;
      mem_we <= grant_d & d_we;
      if (grant_d) begin
        mem_addr  <= d_addr;
        mem_wdata <= d_wdata;
        gnt_d     <= 1'b1;
        gnt_we    <= d_we;
      end else if (grant_i) begin
        mem_addr <= if_addr;
        gnt_d    <= 1'b0;
        gnt_we   <= 1'b0;
      end
      if (if_ack)            if_hold <= mem_rdata;
      if (d_ack && !gnt_we)  d_hold  <= mem_rdata;
    end
  end

  assign if_ack      = done & ~gnt_d & ~reset;
  assign d_ack       = done &  gnt_d & ~reset;
  assign if_rdata    = if_ack ? mem_rdata : if_hold;
  assign d_rdata     = (d_ack && !gnt_we) ? mem_rdata : d_hold;
  assign stall_fetch = ~reset & if_req & ~if_ack;
  assign stall_pipe  = ~reset & d_req & ~d_ack;

endmodule
